// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory-side signals around mem_port_arbiter.
// master = fetch/LSU requesters plus the RAM; slave = the arbiter itself.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ready;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wmask;
    logic                  d_ready;
    logic [DATA_W-1:0]     rdata;
    logic                  err;
    logic                  busy;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
        input  if_ready, d_ready, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
        output if_ready, d_ready, rdata, err, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store: data wins ties,
// a starvation counter forces a fetch, and a watchdog aborts accesses the RAM never acks.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int MASK_W   = DATA_W / 8;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [TO_W-1:0]     TO_LAST    = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                owner_r, owner_s;          // 1 = data access, 0 = fetch
    logic [STARVE_W-1:0] starve_r, starve_s;
    logic [TO_W-1:0]     to_cnt_r, to_cnt_s;

    logic                if_ready_r, if_ready_s;
    logic                d_ready_r, d_ready_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                err_r, err_s;
    logic                busy_r, busy_s;
    logic                mem_req_r, mem_req_s;
    logic                mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [MASK_W-1:0]   mem_wmask_r, mem_wmask_s;

    logic                fetch_win_s;

    // Fetch wins when it is alone or when data has already beaten it STARVE_LIMIT times.
    assign fetch_win_s = bus.if_req && (!bus.d_req || (starve_r == STARVE_MAX));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic; ready/err/rdata default low so they pulse for one cycle.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        starve_s    = starve_r;
        to_cnt_s    = to_cnt_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wmask_s = mem_wmask_r;
        busy_s      = busy_r;
        if_ready_s  = 1'b0;
        d_ready_s   = 1'b0;
        rdata_s     = '0;
        err_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (fetch_win_s) begin
                    state_s     = BUSY;
                    owner_s     = 1'b0;
                    starve_s    = '0;
                    to_cnt_s    = '0;
                    mem_req_s   = 1'b1;
                    mem_we_s    = 1'b0;
                    mem_addr_s  = bus.if_addr;
                    mem_wdata_s = '0;
                    mem_wmask_s = '0;
                    busy_s      = 1'b1;
                end else if (bus.d_req) begin
                    state_s     = BUSY;
                    owner_s     = 1'b1;
                    to_cnt_s    = '0;
                    mem_req_s   = 1'b1;
                    mem_we_s    = bus.d_we;
                    mem_addr_s  = bus.d_addr;
                    mem_wdata_s = bus.d_wdata;
                    mem_wmask_s = bus.d_we ? bus.d_wmask : '0;
                    busy_s      = 1'b1;
                    if (bus.if_req && (starve_r != STARVE_MAX)) begin
                        starve_s = starve_r + STARVE_W'(1);
                    end else begin
                        starve_s = starve_r;
                    end
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            BUSY: begin
                // An ack arriving on the last allowed cycle still completes the access cleanly.
                if (bus.mem_ack) begin
                    state_s    = RESP;
                    mem_req_s  = 1'b0;
                    to_cnt_s   = '0;
                    if_ready_s = !owner_r;
                    d_ready_s  = owner_r;
                    rdata_s    = mem_we_r ? '0 : bus.mem_rdata;
                end else if (to_cnt_r == TO_LAST) begin
                    state_s    = RESP;
                    mem_req_s  = 1'b0;
                    to_cnt_s   = '0;
                    if_ready_s = !owner_r;
                    d_ready_s  = owner_r;
                    err_s      = 1'b1;
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
            end
            RESP: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
            default: begin
                state_s   = IDLE;
                mem_req_s = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Registered outputs and bookkeeping counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_r     <= 1'b0;
            starve_r    <= '0;
            to_cnt_r    <= '0;
            if_ready_r  <= 1'b0;
            d_ready_r   <= 1'b0;
            rdata_r     <= '0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wmask_r <= '0;
        end else begin
            owner_r     <= owner_s;
            starve_r    <= starve_s;
            to_cnt_r    <= to_cnt_s;
            if_ready_r  <= if_ready_s;
            d_ready_r   <= d_ready_s;
            rdata_r     <= rdata_s;
            err_r       <= err_s;
            busy_r      <= busy_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wmask_r <= mem_wmask_s;
        end
    end

    assign bus.if_ready  = if_ready_r;
    assign bus.d_ready   = d_ready_r;
    assign bus.rdata     = rdata_r;
    assign bus.err       = err_r;
    assign bus.busy      = busy_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_wmask = mem_wmask_r;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants and
// responses into queues; independent monitors pop and compare as the DUT presents them.
module tb_mem_port_arbiter;
    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          cycles;
    } grant_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } dreq_t;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .STARVE_LIMIT(4),
        .TIMEOUT(255)
    ) dut (
        .clock(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    resp_t       exp_r[$];
    grant_t      exp_g[$];
    logic [31:0] fq[$];
    dreq_t       dq[$];

    int          n_cmp;
    int          n_fail;
    int          resp_cnt;
    int          mem_lat;
    logic [31:0] mem_val;
    int          spur_req;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_grant(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                input logic [3:0] wm, input int cyc);
        exp_g.push_back('{a, we, wd, wm, cyc});
    endtask

    task automatic expect_resp(input logic is_d, input logic [31:0] rd, input logic e);
        exp_r.push_back('{is_d, rd, e});
    endtask

    task automatic wait_resp(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (resp_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(resp_cnt), 64'(target));
    endtask

    // Fetch requester: holds if_req until if_ready, then takes the next queued address.
    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.if_req = 1'b0;
            end else begin
                if (bus.if_req && bus.if_ready) bus.if_req = 1'b0;
                if (!bus.if_req && fq.size() > 0) begin
                    bus.if_addr = fq.pop_front();
                    bus.if_req  = 1'b1;
                end
            end
        end
    end

    // Load/store requester with the same hold-until-ready discipline.
    initial begin
        dreq_t r;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.d_wmask = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.d_req = 1'b0;
            end else begin
                if (bus.d_req && bus.d_ready) bus.d_req = 1'b0;
                if (!bus.d_req && dq.size() > 0) begin
                    r           = dq.pop_front();
                    bus.d_we    = r.we;
                    bus.d_addr  = r.addr;
                    bus.d_wdata = r.wdata;
                    bus.d_wmask = r.wmask;
                    bus.d_req   = 1'b1;
                end
            end
        end
    end

    // RAM model: acks in the mem_lat-th request cycle (never when 0), plus injected spurious acks.
    initial begin
        int rc;
        int spur_done;
        rc            = 0;
        spur_done     = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hBAD0_BAD0;
            if (bus.mem_req) begin
                rc++;
                if (mem_lat != 0 && rc == mem_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_val;
                end
            end else begin
                rc = 0;
                if (spur_done != spur_req) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = 32'h7777_7777;
                    spur_done++;
                end
            end
        end
    end

    // Response monitor: every ready pulse must match the head of the expected-response queue.
    initial begin
        resp_t e;
        resp_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) begin
                check("one_ready", 64'(bus.if_ready && bus.d_ready), 64'(0));
                if (exp_r.size() == 0) begin
                    check("unexpected_ready", 64'(1), 64'(0));
                end else begin
                    e = exp_r.pop_front();
                    check("resp", {29'd0, bus.d_ready, bus.rdata, bus.err},
                          {29'd0, e.is_data, e.rdata, e.err});
                end
                resp_cnt++;
            end
        end
    end

    // Memory-side monitor: grant contents, hold stability, and mem_req duration.
    initial begin
        grant_t g;
        logic   prev;
        int     dur;
        prev = 1'b0;
        dur  = 0;
        g    = '{32'd0, 1'b0, 32'd0, 4'd0, 0};
        forever begin
            @(negedge clk);
            if (bus.mem_req && !prev) begin
                dur = 1;
                if (exp_g.size() == 0) begin
                    check("unexpected_grant", 64'(1), 64'(0));
                end else begin
                    g = exp_g.pop_front();
                    check("grant_addr_we_mask", {27'd0, bus.mem_addr, bus.mem_we, bus.mem_wmask},
                          {27'd0, g.addr, g.we, g.wmask});
                    if (g.we) check("grant_wdata", 64'(bus.mem_wdata), 64'(g.wdata));
                end
            end else if (bus.mem_req) begin
                dur++;
                check("mem_hold", {27'd0, bus.mem_addr, bus.mem_we, bus.mem_wmask},
                      {27'd0, g.addr, g.we, g.wmask});
            end else if (prev) begin
                check("mem_req_cycles", 64'(dur), 64'(g.cycles));
            end
            prev = bus.mem_req;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_cmp    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        mem_lat  = 1;
        mem_val  = 32'h0;
        spur_req = 0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({bus.if_ready, bus.d_ready, bus.err, bus.busy, bus.mem_req, bus.mem_we}), 64'(0));
        check("rst_rdata", 64'(bus.rdata), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_wdata_mask", {28'd0, bus.mem_wdata, bus.mem_wmask}, 64'(0));
        check("rst_starve", 64'(dut.starve_r), 64'(0));
        check("rst_timeout_cnt", 64'(dut.to_cnt_r), 64'(0));
        reset = 1'b0;

        // 1: lone fetch, ack in second request cycle
        mem_lat = 2;
        mem_val = 32'h0050_0093;
        expect_grant(32'h100, 1'b0, 32'h0, 4'h0, 2);
        expect_resp(1'b0, 32'h0050_0093, 1'b0);
        fq.push_back(32'h100);
        wait_resp(1, 50, "t1_done");

        // 2: simultaneous store and fetch; store goes first and returns rdata 0
        mem_lat = 1;
        mem_val = 32'h0000_0013;
        expect_grant(32'h2000, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1);
        expect_grant(32'h104, 1'b0, 32'h0, 4'h0, 1);
        expect_resp(1'b1, 32'h0, 1'b0);
        expect_resp(1'b0, 32'h0000_0013, 1'b0);
        fq.push_back(32'h104);
        dq.push_back('{1'b1, 32'h2000, 32'hDEAD_BEEF, 4'b0011});
        wait_resp(3, 50, "t2_done");

        // 3: fetch held against back-to-back loads: four loads, then the forced fetch
        mem_val = 32'h0000_0A0A;
        for (int i = 0; i < 4; i++) expect_grant(32'h3000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 1);
        expect_grant(32'h200, 1'b0, 32'h0, 4'h0, 1);
        expect_grant(32'h3010, 1'b0, 32'h0, 4'h0, 1);
        for (int i = 0; i < 4; i++) expect_resp(1'b1, 32'h0000_0A0A, 1'b0);
        expect_resp(1'b0, 32'h0000_0A0A, 1'b0);
        expect_resp(1'b1, 32'h0000_0A0A, 1'b0);
        fq.push_back(32'h200);
        for (int i = 0; i < 5; i++) dq.push_back('{1'b0, 32'h3000 + 32'(4 * i), 32'h5555_5555, 4'hF});
        wait_resp(9, 100, "t3_done");
        check("t3_starve_cleared", 64'(dut.starve_r), 64'(0));

        // 4: no ack at all -> abort after 255 request cycles, then a normal load
        mem_lat = 0;
        expect_grant(32'h300, 1'b0, 32'h0, 4'h0, 255);
        expect_resp(1'b0, 32'h0, 1'b1);
        fq.push_back(32'h300);
        wait_resp(10, 400, "t4_timeout_done");
        mem_lat = 1;
        mem_val = 32'h1234_5678;
        expect_grant(32'h40, 1'b0, 32'h0, 4'h0, 1);
        expect_resp(1'b1, 32'h1234_5678, 1'b0);
        dq.push_back('{1'b0, 32'h40, 32'h0, 4'h0});
        wait_resp(11, 50, "t4_after_done");

        // 5: reset in the second BUSY cycle
        mem_lat = 0;
        expect_grant(32'h500, 1'b0, 32'h0, 4'h0, 2);
        fq.push_back(32'h500);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 20);
        check("t5_saw_mem_req", 64'(bus.mem_req), 64'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_abort_state", 64'({bus.mem_req, bus.busy, bus.if_ready, bus.d_ready}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_no_resp", 64'(resp_cnt), 64'(11));
        mem_lat = 1;
        mem_val = 32'h0000_0513;
        expect_grant(32'h504, 1'b0, 32'h0, 4'h0, 1);
        expect_resp(1'b0, 32'h0000_0513, 1'b0);
        fq.push_back(32'h504);
        wait_resp(12, 50, "t5_after_done");

        // 6: ack on the very cycle the watchdog would fire, then a stray ack in IDLE
        mem_lat = 255;
        mem_val = 32'hCAFE_F00D;
        expect_grant(32'h600, 1'b0, 32'h0, 4'h0, 255);
        expect_resp(1'b0, 32'hCAFE_F00D, 1'b0);
        fq.push_back(32'h600);
        wait_resp(13, 400, "t6_done");
        @(negedge clk);
        spur_req = 1;
        repeat (6) @(negedge clk);
        check("t6_spurious_no_resp", 64'(resp_cnt), 64'(13));
        check("t6_idle_after_spurious", 64'({bus.busy, bus.mem_req}), 64'(0));

        check("exp_resp_drained", 64'(exp_r.size()), 64'(0));
        check("exp_grant_drained", 64'(exp_g.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
